// File: rtl/mips.sv
// mips: 5-stage in-order MIPS pipeline (IF/ID/EX/MEM/WB) with internal memories.
// No forwarding or hazard handling; taken branches leave three delay slots.
module mips #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 1024
) (
  input logic clk,
  input logic rst
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_BYTES);
  logic [31:0] imem [IMEM_WORDS];
  logic [7:0] dmem [DMEM_BYTES];
  logic [31:0] regs [32];
  logic [31:0] pc, pc4, instr;
  logic [31:0] id_pc4, id_instr;
  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_extended_bits;
  logic [4:0] ex_rt, ex_rd;
  logic ex_regdst, ex_regwrite, ex_alusrc, ex_memwrite, ex_memread, ex_memtoreg, ex_branch;
  logic [1:0] ex_loadmode, ex_aluop;
  logic mem_regwrite, mem_memwrite, mem_memread, mem_memtoreg, mem_branch, mem_zero;
  logic [31:0] mem_branch_address, mem_alu, mem_wdata;
  logic [4:0] mem_dest;
  logic [1:0] mem_loadmode;
  logic [4:0] wb_dest;
  logic wb_regwrite, wb_memtoreg;
  logic [31:0] wb_rdata, wb_alu;
  logic [10:0] ctl;
  logic [4:0] rs, rt;
  logic [31:0] rd1, rd2, wb_data, opb, alu, word, ld;
  logic wb_we;
  logic [DAW-1:0] a;
  assign pc4 = pc + 32'd4;
  assign instr = imem[pc[IAW+1:2]];
  assign rs = id_instr[25:21];
  assign rt = id_instr[20:16];
  // {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, LoadMode}
  always_comb
    case (id_instr[31:26])
      6'h00: ctl = 11'b1_0_0_1_0_0_0_10_00;
      6'h08: ctl = 11'b0_1_0_1_0_0_0_00_00;
      6'h23: ctl = 11'b0_1_1_1_1_0_0_00_00;
      6'h20: ctl = 11'b0_1_1_1_1_0_0_00_01;
      6'h24: ctl = 11'b0_1_1_1_1_0_0_00_10;
      6'h2b: ctl = 11'b0_1_0_0_0_1_0_00_00;
      6'h04: ctl = 11'b0_0_0_0_0_0_1_01_00;
      default: ctl = '0;
    endcase
  // write-before-read: the value being written back this cycle is visible to ID
  assign wb_data = wb_memtoreg ? wb_rdata : wb_alu;
  assign wb_we = wb_regwrite && wb_dest != 5'd0;
  assign rd1 = rs == 5'd0 ? '0 : (wb_we && wb_dest == rs) ? wb_data : regs[rs];
  assign rd2 = rt == 5'd0 ? '0 : (wb_we && wb_dest == rt) ? wb_data : regs[rt];
  assign opb = ex_alusrc ? ex_extended_bits : ex_rd2;
  always_comb
    case (ex_aluop)
      2'b00: alu = ex_rd1 + opb;
      2'b01: alu = ex_rd1 - opb;
      2'b10:
        case (ex_extended_bits[5:0])
          6'h20: alu = ex_rd1 + opb;
          6'h22: alu = ex_rd1 - opb;
          6'h24: alu = ex_rd1 & opb;
          6'h25: alu = ex_rd1 | opb;
          6'h2a: alu = {31'b0, $signed(ex_rd1) < $signed(opb)};
          6'h00: alu = ex_rd2 << ex_extended_bits[10:6];
          6'h02: alu = ex_rd2 >> ex_extended_bits[10:6];
          default: alu = '0;
        endcase
      default: alu = '0;
    endcase
  assign a = mem_alu[DAW-1:0];
  assign word = {dmem[a + DAW'(3)], dmem[a + DAW'(2)], dmem[a + DAW'(1)], dmem[a]};
  assign ld = mem_loadmode == 2'b01 ? {{24{word[7]}}, word[7:0]} :
              mem_loadmode == 2'b10 ? {24'b0, word[7:0]} : word;
  always_ff @(posedge clk)
    if (rst) begin
      pc <= '0;
      {id_pc4, id_instr} <= '0;
      {ex_pc4, ex_rd1, ex_rd2, ex_extended_bits, ex_rt, ex_rd} <= '0;
      {ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_aluop, ex_loadmode} <= '0;
      {mem_regwrite, mem_memwrite, mem_memread, mem_memtoreg, mem_branch, mem_zero} <= '0;
      {mem_branch_address, mem_alu, mem_wdata, mem_dest, mem_loadmode} <= '0;
      {wb_dest, wb_regwrite, wb_memtoreg, wb_rdata, wb_alu} <= '0;
    end else begin
      pc <= (mem_branch && mem_zero) ? mem_branch_address : pc4;
      id_pc4 <= pc4;
      id_instr <= instr;
      ex_pc4 <= id_pc4;
      ex_rd1 <= rd1;
      ex_rd2 <= rd2;
      ex_extended_bits <= {{16{id_instr[15]}}, id_instr[15:0]};
      ex_rt <= rt;
      ex_rd <= id_instr[15:11];
      {ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_aluop, ex_loadmode} <= ctl;
      mem_regwrite <= ex_regwrite;
      mem_memwrite <= ex_memwrite;
      mem_memread <= ex_memread;
      mem_memtoreg <= ex_memtoreg;
      mem_branch <= ex_branch;
      mem_zero <= alu == 32'd0;
      mem_branch_address <= ex_pc4 + {ex_extended_bits[29:0], 2'b00};
      mem_alu <= alu;
      mem_wdata <= ex_rd2;
      mem_dest <= ex_regdst ? ex_rd : ex_rt;
      mem_loadmode <= ex_loadmode;
      wb_dest <= mem_dest;
      wb_regwrite <= mem_regwrite;
      wb_memtoreg <= mem_memtoreg;
      wb_rdata <= mem_memread ? ld : '0;
      wb_alu <= mem_alu;
    end
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (wb_we)
      regs[wb_dest] <= wb_data;
  // little-endian store; addresses wrap within the data memory
  always_ff @(posedge clk)
    if (!rst && mem_memwrite)
      for (int k = 0; k < 4; k++) dmem[a + DAW'(k)] <= mem_wdata[8*k +: 8];
endmodule

// File: tb/tb_mips.sv
// tb_mips: directed scenarios plus random straight-line programs checked
// against an instruction-level model of the mips pipeline.
module tb_mips;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  logic [31:0] prog[$];

  mips dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  function automatic logic [31:0] ienc(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] renc(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [4:0] sh, logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] alu_ref(logic [5:0] fn, logic [31:0] x, logic [31:0] y, logic [4:0] sh);
    case (fn)
      6'h20: return x + y;
      6'h22: return x - y;
      6'h24: return x & y;
      6'h25: return x | y;
      6'h2a: return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      6'h00: return y << sh;
      6'h02: return y >> sh;
      default: return 32'd0;
    endcase
  endfunction

  task automatic restart;
    @(negedge clk);
    for (int i = 0; i < 256; i++) dut.imem[i] = i < prog.size() ? prog[i] : 32'h0;
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    prog = {32'h21090002};
    restart();
    total++; if (dut.pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", dut.pc); end
    total++; if (dut.id_instr !== 32'd0) begin bad++; $display("FAIL reset_id_instr got=%h exp=0", dut.id_instr); end
    total++; if (dut.ex_regwrite !== 1'b0) begin bad++; $display("FAIL reset_ex_regwrite got=%b exp=0", dut.ex_regwrite); end
    total++; if (dut.regs[9] !== 32'd0) begin bad++; $display("FAIL reset_reg9 got=%h exp=0", dut.regs[9]); end
    step(2);
    total++; if (dut.ex_alusrc !== 1'b1) begin bad++; $display("FAIL addi_ex_alusrc got=%b exp=1", dut.ex_alusrc); end
    total++; if (dut.ex_regdst !== 1'b0) begin bad++; $display("FAIL addi_ex_regdst got=%b exp=0", dut.ex_regdst); end
    total++; if (dut.ex_extended_bits !== 32'd2) begin bad++; $display("FAIL addi_ex_imm got=%h exp=2", dut.ex_extended_bits); end
    step(2);
    total++; if (dut.regs[9] !== 32'd0) begin bad++; $display("FAIL addi_reg9_early got=%h exp=0", dut.regs[9]); end
    step(1);
    total++; if (dut.regs[9] !== 32'd2) begin bad++; $display("FAIL addi_reg9 got=%h exp=2", dut.regs[9]); end
    total++; if (dut.pc !== 32'd20) begin bad++; $display("FAIL addi_pc got=%0d exp=20", dut.pc); end
  endtask

  task automatic test_rtype;
    prog = {ienc(6'h08, 0, 1, 16'd7), ienc(6'h08, 0, 2, 16'd5), 32'h0, 32'h0,
            renc(1, 2, 3, 0, 6'h20), renc(1, 2, 4, 0, 6'h22), renc(2, 1, 5, 0, 6'h2a)};
    restart();
    step(12);
    total++; if (dut.regs[3] !== 32'd12) begin bad++; $display("FAIL rtype_add got=%h exp=c", dut.regs[3]); end
    total++; if (dut.regs[4] !== 32'd2) begin bad++; $display("FAIL rtype_sub got=%h exp=2", dut.regs[4]); end
    total++; if (dut.regs[5] !== 32'd1) begin bad++; $display("FAIL rtype_slt got=%h exp=1", dut.regs[5]); end
  endtask

  task automatic test_memory;
    prog = {ienc(6'h08, 0, 1, 16'hffff), 32'h0, 32'h0, ienc(6'h2b, 0, 1, 16'd8),
            ienc(6'h23, 0, 2, 16'd8), ienc(6'h20, 0, 3, 16'd8), ienc(6'h24, 0, 4, 16'd8)};
    restart();
    step(12);
    total++; if (dut.regs[2] !== 32'hffffffff) begin bad++; $display("FAIL mem_lw got=%h exp=ffffffff", dut.regs[2]); end
    total++; if (dut.regs[3] !== 32'hffffffff) begin bad++; $display("FAIL mem_lb got=%h exp=ffffffff", dut.regs[3]); end
    total++; if (dut.regs[4] !== 32'h000000ff) begin bad++; $display("FAIL mem_lbu got=%h exp=000000ff", dut.regs[4]); end
  endtask

  task automatic test_branch;
    prog = {ienc(6'h04, 0, 0, 16'd4)};
    for (int i = 1; i <= 5; i++) prog.push_back(ienc(6'h08, 0, 5'(i), 16'(i)));
    restart();
    step(3);
    total++; if (dut.pc !== 32'd12) begin bad++; $display("FAIL branch_pc_before got=%0d exp=12", dut.pc); end
    step(1);
    total++; if (dut.pc !== 32'd20) begin bad++; $display("FAIL branch_pc_taken got=%0d exp=20", dut.pc); end
    step(10);
    for (int i = 1; i <= 5; i++) begin
      total++;
      if (dut.regs[i] !== (i == 4 ? 32'd0 : 32'(i))) begin
        bad++; $display("FAIL branch_reg%0d got=%h exp=%h", i, dut.regs[i], (i == 4 ? 32'd0 : 32'(i)));
      end
    end
  endtask

  task automatic test_zero_reg;
    prog = {ienc(6'h08, 0, 0, 16'd5), 32'h0, 32'h0, ienc(6'h08, 0, 7, 16'd1)};
    restart();
    step(10);
    total++; if (dut.regs[0] !== 32'd0) begin bad++; $display("FAIL zero_reg0 got=%h exp=0", dut.regs[0]); end
    total++; if (dut.regs[7] !== 32'd1) begin bad++; $display("FAIL zero_read_bypass got=%h exp=1", dut.regs[7]); end
  endtask

  task automatic test_reset_mid;
    prog.delete();
    for (int i = 1; i <= 6; i++) prog.push_back(ienc(6'h08, 0, 5'(i), 16'(i)));
    restart();
    step(7);
    total++; if (dut.regs[1] !== 32'd1) begin bad++; $display("FAIL midrst_pre_reg1 got=%h exp=1", dut.regs[1]); end
    rst = 1;
    @(negedge clk);
    total++; if (dut.pc !== 32'd0) begin bad++; $display("FAIL midrst_pc got=%h exp=0", dut.pc); end
    total++; if (dut.id_instr !== 32'd0 || dut.id_pc4 !== 32'd0) begin bad++; $display("FAIL midrst_ifid got=%h/%h exp=0", dut.id_instr, dut.id_pc4); end
    total++; if (dut.ex_regwrite !== 1'b0 || dut.ex_extended_bits !== 32'd0) begin bad++; $display("FAIL midrst_idex got=%b/%h exp=0", dut.ex_regwrite, dut.ex_extended_bits); end
    total++; if (dut.mem_regwrite !== 1'b0 || dut.mem_alu !== 32'd0) begin bad++; $display("FAIL midrst_exmem got=%b/%h exp=0", dut.mem_regwrite, dut.mem_alu); end
    total++; if (dut.wb_regwrite !== 1'b0 || dut.wb_alu !== 32'd0) begin bad++; $display("FAIL midrst_memwb got=%b/%h exp=0", dut.wb_regwrite, dut.wb_alu); end
    for (int i = 1; i <= 6; i++) begin
      total++; if (dut.regs[i] !== 32'd0) begin bad++; $display("FAIL midrst_reg%0d got=%h exp=0", i, dut.regs[i]); end
    end
    rst = 0;
  endtask

  task automatic test_random;
    logic [31:0] r[32];
    logic [31:0] mw[16];
    bit wr[16];
    logic [5:0] fns[7];
    logic [4:0] rs, rt, rd, sh;
    logic [15:0] imm;
    logic [7:0] by;
    logic [5:0] fn;
    int kind, w, b, nw;
    logic [31:0] got;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02};
    for (int i = 0; i < 32; i++) r[i] = 32'd0;
    for (int i = 0; i < 16; i++) begin mw[i] = 32'd0; wr[i] = 0; end
    nw = 0;
    prog.delete();
    for (int k = 0; k < 20; k++) begin
      kind = $urandom_range(0, 5);
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      sh = 5'($urandom_range(0, 31));
      imm = 16'($urandom);
      w = $urandom_range(0, 15);
      b = $urandom_range(0, 3);
      if (kind >= 3) begin
        if (nw == 0) kind = 0;
        else while (!wr[w]) w = $urandom_range(0, 15);
      end
      by = 8'(mw[w] >> (8 * b));
      case (kind)
        0: begin
          prog.push_back(ienc(6'h08, rs, rt, imm));
          if (rt != 0) r[rt] = r[rs] + 32'(signed'(imm));
        end
        1: begin
          fn = fns[$urandom_range(0, 6)];
          prog.push_back(renc(rs, rt, rd, sh, fn));
          if (rd != 0) r[rd] = alu_ref(fn, r[rs], r[rt], sh);
        end
        2: begin
          prog.push_back(ienc(6'h2b, 0, rt, 16'(512 + 4 * w)));
          mw[w] = r[rt];
          if (!wr[w]) nw++;
          wr[w] = 1;
        end
        3: begin
          prog.push_back(ienc(6'h23, 0, rt, 16'(512 + 4 * w)));
          if (rt != 0) r[rt] = mw[w];
        end
        4: begin
          prog.push_back(ienc(6'h20, 0, rt, 16'(512 + 4 * w + b)));
          if (rt != 0) r[rt] = 32'(signed'(by));
        end
        default: begin
          prog.push_back(ienc(6'h24, 0, rt, 16'(512 + 4 * w + b)));
          if (rt != 0) r[rt] = {24'd0, by};
        end
      endcase
      prog.push_back(32'h0);
      prog.push_back(32'h0);
    end
    restart();
    step(66);
    for (int i = 0; i < 32; i++) begin
      total++; if (dut.regs[i] !== r[i]) begin bad++; $display("FAIL rand_reg%0d got=%h exp=%h", i, dut.regs[i], r[i]); end
    end
    for (int i = 0; i < 16; i++)
      if (wr[i]) begin
        got = {dut.dmem[512 + 4 * i + 3], dut.dmem[512 + 4 * i + 2], dut.dmem[512 + 4 * i + 1], dut.dmem[512 + 4 * i]};
        total++; if (got !== mw[i]) begin bad++; $display("FAIL rand_mem%0d got=%h exp=%h", i, got, mw[i]); end
      end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_memory;
    test_branch;
    test_zero_reg;
    test_reset_mid;
    repeat (3) test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips.md
Name: mips

Overview:
- Top-level 32-bit MIPS processor: classic 5-stage in-order pipeline (IF, ID, EX, MEM, WB).
- Separate instruction memory (word array), data memory (byte array) and a 32x32 register file, all internal.
- The bench preloads instruction memory and registers hierarchically, then probes the pipeline registers and control signals.
- No forwarding, hazard detection or flushing; software inserts nops.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words (word-indexed by PC[31:2]).
- DMEM_BYTES, 1024, data memory size in bytes; byte addresses wrap modulo DMEM_BYTES.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.

Behaviour:
- Reset (rst=1 at rising edge):
  - PC=0; all IF/ID, ID/EX, EX/MEM and MEM/WB fields=0 (i.e. a nop bubble).
  - Register file cleared to 0.
  - Instruction and data memories not reset; both power up as all zeros (word 0x00000000 = nop).
- IF:
  - Fetches imem[PC[31:2]]; PC+4 computed.
  - PC update each cycle: PC <= (MEM_branch & MEM_zero) ? branch_address : PC+4.
  - IF/ID latches PC+4 and instruction.
- ID:
  - Decode opcode [31:26]; read rs [25:21] and rt [20:16]; sign-extend imm [15:0] to 32 bits.
  - Register file write-before-read: a WB write to the register being read in the same cycle returns the new value.
  - Register 0 always reads 0 and ignores writes.
  - ID/EX latches: PC+4, read data 1/2, extended imm, instr[20:16], instr[15:11], and control RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch, LoadMode[1:0], ALUOp[1:0].
- Control per opcode (RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, LoadMode):
  - R-type 0x00: 1,0,0,1,0,0,0,10,00.
  - addi 0x08: 0,1,0,1,0,0,0,00,00.
  - lw 0x23: 0,1,1,1,1,0,0,00,00.
  - lb 0x20: as lw, LoadMode=01.
  - lbu 0x24: as lw, LoadMode=10.
  - sw 0x2B: 0,1,0,0,0,1,0,00,00.
  - beq 0x04: 0,0,0,0,0,0,1,01,00.
  - Any other opcode: all control 0.
- EX:
  - ALU operand B = ALUSrc ? imm : rd2.
  - ALUOp 00=add, 01=sub.
  - ALUOp 10 uses funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 1/0), 0x00 sll, 0x02 srl (shift rd2 by shamt [10:6]); unknown funct gives result 0.
  - zero = (result==0); arithmetic wraps mod 2^32, no overflow trap.
  - branch_address = PC+4 + (imm<<2).
  - Writeback destination = RegDst ? instr[15:11] : instr[20:16].
  - EX/MEM latches: RegWrite, MemWrite, MemRead, MemToReg, branch_address, zero, ALU result, write data (rd2), destination, LoadMode, Branch.
- MEM:
  - Memory is little-endian.
  - sw writes 4 bytes at address..address+3.
  - Loads read combinationally:
    - LoadMode 00: word.
    - 01: byte sign-extended.
    - 10: byte zero-extended.
    - 11: treated as 00.
  - Taken branch redirects PC at the end of this cycle. The three younger instructions are not squashed (3 delay slots).
  - MEM/WB latches: destination, RegWrite, read data, ALU result, MemToReg.
- WB: if RegWrite, reg[dest] <= MemToReg ? read data : ALU result, at the rising edge.
- Latency: an instruction fetched at edge N writes the register file at edge N+4. A dependent instruction needs 2 intervening instructions (write-before-read covers the third).

Test Plan:
- Reset, imem[0]=addi $9,$8,2 (0x21090002), rest zero -> 5th edge after reset release: reg[9]=2; mid-pipeline at edge 2: EX_ALUSrc=1, EX_RegDst=0, EX_extended_bits=2; PC=20 after 5 edges.
- R-type sequence: addi $1,$0,7; addi $2,$0,5; 2 nops; add $3,$1,$2; sub $4,$1,$2; slt $5,$2,$1 -> reg3=12, reg4=2, reg5=1.
- Memory: addi $1,$0,-1; 2 nops; sw $1,8($0); lw $2,8($0); lb $3,8($0); lbu $4,8($0) -> reg2=0xFFFFFFFF, reg3=0xFFFFFFFF, reg4=0x000000FF.
- Branch: beq $0,$0,+4 at address 0 -> PC=20 after MEM stage. Instructions at 4, 8, 12 still execute; instruction at 16 is skipped.
- Write to $0: addi $0,$0,5 -> reg[0] reads 0.
- Reset mid-run: assert rst during the addi sequence -> next edge PC=0, all pipeline fields 0, registers 0.
